// File: rtl/door_ctrl_pkg.sv
// Shared types and helpers for the door motor sequencer.
// State encoding matches the door_state output pins.
package door_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_CLOSED    = 3'd1,
    ST_DEAD      = 3'd2,
    ST_OPENING   = 3'd3,
    ST_OPEN_HOLD = 3'd4,
    ST_CLOSING   = 3'd5,
    ST_FAULT     = 3'd6
  } door_state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int DEF_RUN_TIMEOUT = 1000;
  localparam int DEF_HOLD_TIME   = 500;
  localparam int DEF_DEAD_TIME   = 4;

  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int TIMER_W =
    timer_w(DEF_RUN_TIMEOUT, DEF_HOLD_TIME, DEF_DEAD_TIME);

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, debounce filter, rising-edge pulse.
// Level changes only after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) stable_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
    rise_d = stable_d & ~stable_q;
  end

  // Filter state and one-cycle press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/door_motor_sequencer.sv
// Push-button door motor sequencer: open/hold/close with dead time,
// limit stops, obstacle reversal, run timeout and sticky fault.
module door_motor_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int RUN_TIMEOUT  = 1000,
  parameter int HOLD_TIME    = 500,
  parameter int DEAD_TIME    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       lim_open,
  input  logic       lim_closed,
  input  logic       obstacle,
  output logic       open_cw,
  output logic       open_ccw,
  output logic [2:0] door_state,
  output logic       fault
);

  import door_ctrl_pkg::*;

  localparam int TW = timer_w(RUN_TIMEOUT, HOLD_TIME, DEAD_TIME);

  logic        press_evt;
  logic [2:0]  sy1_q, sy2_q;
  logic        lo, lc, obs;

  door_state_e state_q, state_d;
  door_state_e target_q, target_d;
  logic        last_dir_q, last_dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        cw_q, cw_d;
  logic        ccw_q, ccw_d;
  logic        fault_q, fault_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_press (
    .clk  (clk),
    .rst  (rst),
    .din  (press),
    .rise (press_evt)
  );

  // Plain 2-flop syncs for limits and obstacle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy1_q <= '0;
      sy2_q <= '0;
    end else begin
      sy1_q <= {obstacle, lim_closed, lim_open};
      sy2_q <= sy1_q;
    end
  end

  assign lo  = sy2_q[0];
  assign lc  = sy2_q[1];
  assign obs = sy2_q[2];

  // Next state, timer and registered motor outputs.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    last_dir_d = last_dir_q;
    if (state_q != ST_FAULT && lo && lc) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_STOPPED: if (press_evt) begin
          state_d  = ST_DEAD;
          target_d = (last_dir_q == DIR_CW) ? ST_CLOSING : ST_OPENING;
        end
        ST_CLOSED: if (press_evt) begin
          state_d  = ST_DEAD;
          target_d = ST_OPENING;
        end
        ST_DEAD:
          if (timer_q == TW'(DEAD_TIME - 1)) state_d = target_q;
        ST_OPENING:
          if (lo) state_d = ST_OPEN_HOLD;
          else if (press_evt) state_d = ST_STOPPED;
          else if (timer_q == TW'(RUN_TIMEOUT - 1)) state_d = ST_FAULT;
        ST_OPEN_HOLD:
          if (press_evt || timer_q == TW'(HOLD_TIME - 1)) begin
            state_d  = ST_DEAD;
            target_d = ST_CLOSING;
          end
        ST_CLOSING:
          if (obs) begin
            state_d  = ST_DEAD;
            target_d = ST_OPENING;
          end else if (lc) state_d = ST_CLOSED;
          else if (press_evt) state_d = ST_STOPPED;
          else if (timer_q == TW'(RUN_TIMEOUT - 1)) state_d = ST_FAULT;
        ST_FAULT: state_d = ST_FAULT;
        default: state_d = ST_STOPPED;
      endcase
    end

    if (state_d == ST_OPENING) last_dir_d = DIR_CW;
    if (state_d == ST_CLOSING) last_dir_d = DIR_CCW;

    if (state_d != state_q) timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + 1'b1;
    else timer_d = timer_q;

    cw_d    = (state_d == ST_OPENING);
    ccw_d   = (state_d == ST_CLOSING);
    fault_d = (state_d == ST_FAULT);
  end

  // State, timer and output registers; reset kills the motor at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOPPED;
      target_q   <= ST_OPENING;
      last_dir_q <= DIR_CCW;
      timer_q    <= '0;
      cw_q       <= 1'b0;
      ccw_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      last_dir_q <= last_dir_d;
      timer_q    <= timer_d;
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      fault_q    <= fault_d;
    end
  end

  assign open_cw    = cw_q;
  assign open_ccw   = ccw_q;
  assign door_state = state_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_door_motor_sequencer.sv
// Directed bench for door_motor_sequencer with shortened timings.
// Scenario tasks run in order from one initial block.
module tb_door_motor_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press = 1'b0;
  logic       lim_open = 1'b0;
  logic       lim_closed = 1'b0;
  logic       obstacle = 1'b0;
  logic       open_cw, open_ccw, fault;
  logic [2:0] door_state;

  int checks = 0;
  int errors = 0;

  logic [2:0] prev_st = 3'd0;
  int cur_len = 0;
  int len_of [8];
  int dead_entries = 0;

  door_motor_sequencer #(
    .DEBOUNCE_CYC(4),
    .RUN_TIMEOUT (50),
    .HOLD_TIME   (20),
    .DEAD_TIME   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .lim_open  (lim_open),
    .lim_closed(lim_closed),
    .obstacle  (obstacle),
    .open_cw   (open_cw),
    .open_ccw  (open_ccw),
    .door_state(door_state),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
    checks++;
    if (open_cw && open_ccw) begin
      errors++;
      $display("FAIL motor_excl cw=%0b ccw=%0b required not both", open_cw, open_ccw);
    end
    if (door_state != prev_st) begin
      len_of[prev_st] = cur_len;
      cur_len = 1;
      if (door_state == 3'd2) dead_entries++;
      prev_st = door_state;
    end else begin
      cur_len++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound);
    int n;
    n = 0;
    while (door_state != s && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (door_state != s) begin
      errors++;
      $display("FAIL wait_state got %0d required %0d", door_state, s);
    end
  endtask

  task automatic press_btn(input int n);
    press = 1'b1;
    repeat (n) tick();
    press = 1'b0;
    repeat (8) tick();
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_state", door_state, 0);
    chk("rst_cw", open_cw, 0);
    chk("rst_ccw", open_ccw, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    tick();
    chk("idle_state", door_state, 0);
  endtask

  task automatic test_full_cycle();
    press_btn(10);
    wait_state(3'd3, 20);
    chk("fc_dead_len", len_of[2], 3);
    chk("fc_cw_on", open_cw, 1);
    chk("fc_ccw_off", open_ccw, 0);
    lim_open = 1'b1;
    tick();
    tick();
    chk("fc_lim_edge2_cw", open_cw, 1);
    tick();
    chk("fc_lim_edge3_cw", open_cw, 0);
    chk("fc_hold_state", door_state, 4);
    wait_state(3'd2, 40);
    chk("fc_hold_len", len_of[4], 20);
    lim_open = 1'b0;
    wait_state(3'd5, 10);
    chk("fc_dead2_len", len_of[2], 3);
    chk("fc_ccw_on", open_ccw, 1);
    lim_closed = 1'b1;
    tick();
    tick();
    chk("fc_lc_edge2_ccw", open_ccw, 1);
    tick();
    chk("fc_lc_edge3_ccw", open_ccw, 0);
    chk("fc_closed_state", door_state, 1);
    lim_closed = 1'b0;
  endtask

  task automatic test_bounce();
    int base;
    base = dead_entries;
    for (int i = 0; i < 5; i++) begin
      press = 1'b1;
      repeat (2) tick();
      press = 1'b0;
      repeat (2) tick();
    end
    repeat (8) tick();
    chk("bnc_state", door_state, 1);
    chk("bnc_no_evt", dead_entries - base, 0);
    press_btn(8);
    wait_state(3'd3, 20);
    chk("bnc_one_evt", dead_entries - base, 1);
    repeat (10) tick();
    chk("bnc_still_open", door_state, 3);
    chk("bnc_evt_once", dead_entries - base, 1);
  endtask

  task automatic test_press_in_opening();
    press_btn(8);
    wait_state(3'd0, 20);
    chk("pio_cw_off", open_cw, 0);
    chk("pio_ccw_off", open_ccw, 0);
    press_btn(8);
    wait_state(3'd5, 20);
    chk("pio_dead_len", len_of[2], 3);
    chk("pio_ccw_on", open_ccw, 1);
    chk("pio_cw_off2", open_cw, 0);
  endtask

  task automatic test_obstacle();
    obstacle = 1'b1;
    tick();
    tick();
    chk("obs_edge2_ccw", open_ccw, 1);
    tick();
    chk("obs_edge3_ccw", open_ccw, 0);
    chk("obs_dead_state", door_state, 2);
    obstacle = 1'b0;
    wait_state(3'd3, 10);
    chk("obs_dead_len", len_of[2], 3);
    chk("obs_cw_on", open_cw, 1);
  endtask

  task automatic test_timeout();
    wait_state(3'd6, 80);
    chk("to_run_len", len_of[3], 50);
    chk("to_fault", fault, 1);
    chk("to_cw_off", open_cw, 0);
    chk("to_ccw_off", open_ccw, 0);
    press_btn(8);
    repeat (5) tick();
    chk("to_press_ignored", door_state, 6);
    chk("to_fault_sticky", fault, 1);
    do_reset();
    chk("to_rst_state", door_state, 0);
    chk("to_rst_fault", fault, 0);
  endtask

  task automatic test_both_limits();
    lim_open = 1'b1;
    lim_closed = 1'b1;
    tick();
    tick();
    chk("bl_edge2_state", door_state, 0);
    tick();
    chk("bl_fault_state", door_state, 6);
    chk("bl_fault", fault, 1);
    lim_open = 1'b0;
    lim_closed = 1'b0;
    do_reset();
    chk("bl_rst_state", door_state, 0);
  endtask

  task automatic test_async_reset();
    press_btn(8);
    wait_state(3'd3, 20);
    lim_open = 1'b1;
    wait_state(3'd4, 10);
    lim_open = 1'b0;
    press_btn(8);
    wait_state(3'd5, 20);
    chk("ar_ccw_before", open_ccw, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_ccw_async", open_ccw, 0);
    chk("ar_cw_async", open_cw, 0);
    chk("ar_state_async", door_state, 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) len_of[i] = 0;
    test_reset();
    test_full_cycle();
    test_bounce();
    test_press_in_opening();
    test_obstacle();
    test_timeout();
    test_both_limits();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
